// File: rtl/test_status_monitor_pkg.sv
// Shared types and constants for the riscv-tests status monitor.
//   state_e     : monitor state (RUN, then one absorbing end state)
//   RegTestnum  : register index holding the test number (x3)
//   RegDone     : register index holding the end flag (x26)
//   RegResult   : register index holding the result (x27)
package test_status_monitor_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StPass    = 2'd1,
    StFail    = 2'd2,
    StTimeout = 2'd3
  } state_e;

  localparam logic [4:0] RegTestnum = 5'd3;
  localparam logic [4:0] RegDone    = 5'd26;
  localparam logic [4:0] RegResult  = 5'd27;

endpackage

// File: rtl/tsm_watchdog.sv
// Saturating cycle counter with a timeout compare.
// Ports:
//   clk     in   core clock
//   rst     in   asynchronous active-high reset, clears cnt
//   en      in   count this cycle
//   cnt     out  cycles counted; saturates at all-ones
//   expire  out  cnt == TIMEOUT_CYCLES-1 (never set when TIMEOUT_CYCLES == 0)
module tsm_watchdog
  import test_status_monitor_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  // Wraps harmlessly when TIMEOUT_CYCLES == 0; the compare is gated off then.
  localparam logic [CNT_W-1:0] ExpireAt = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam bit               TimeoutOn = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  assign cnt    = cnt_q;
  assign expire = TimeoutOn && (cnt_q == ExpireAt);

endmodule

// File: rtl/test_status_monitor.sv
// Pass/fail/timeout detector for riscv-tests ISA programs. Snoops the register
// file write port and keeps shadows of x3 (test number) and x27 (result).
// Ports:
//   clk        in   core clock
//   rst        in   asynchronous active-high reset
//   wr_en      in   regfile write enable
//   wr_addr    in   regfile write index
//   wr_data    in   regfile write data
//   done       out  finished (pass or fail), sticky
//   pass       out  finished with x27 == 1, sticky
//   fail       out  finished with x27 != 1, sticky
//   timeout    out  counter expired before finish, sticky
//   testnum    out  low 32 bits of x3 shadow, frozen once out of RUN
//   cycle_cnt  out  cycles spent in RUN, frozen once out of RUN
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      testnum,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [XLEN-1:0] XlenOne = XLEN'(1);

  state_e          state_q;
  logic [31:0]     x3_q;
  logic [XLEN-1:0] x27_q;
  logic            run;
  logic            finish;
  logic            expire;

  assign run = (state_q == StRun);

  // The end flag is decoded straight from the write port; only its write
  // event matters, so no x26 copy is kept.
  assign finish = wr_en && (wr_addr == RegDone) && (wr_data == XlenOne);

  tsm_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .cnt    (cycle_cnt),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      x3_q    <= '0;
      x27_q   <= '0;
    end else if (run) begin
      if (wr_en && (wr_addr == RegTestnum)) x3_q  <= wr_data[31:0];
      if (wr_en && (wr_addr == RegResult))  x27_q <= wr_data;
      // Finish has priority over a coincident timeout. x27 cannot be written
      // on the finish edge (single port), so the current shadow is final.
      if (finish) begin
        state_q <= (x27_q == XlenOne) ? StPass : StFail;
      end else if (expire) begin
        state_q <= StTimeout;
      end
    end
  end

  assign pass    = (state_q == StPass);
  assign fail    = (state_q == StFail);
  assign done    = pass | fail;
  assign timeout = (state_q == StTimeout);
  assign testnum = x3_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor. Main DUT uses TIMEOUT_CYCLES=20;
// a second narrow-counter DUT with timeout disabled covers saturation.
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;

  logic        done, pass, fail, timeout;
  logic [31:0] testnum;
  logic [31:0] cycle_cnt;

  logic        done2, pass2, fail2, timeout2;
  logic [31:0] testnum2;
  logic [3:0]  cycle_cnt2;
  logic        wr_en2 = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  test_status_monitor #(
    .XLEN           (64),
    .CNT_W          (32),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .testnum   (testnum),
    .cycle_cnt (cycle_cnt)
  );

  test_status_monitor #(
    .XLEN           (64),
    .CNT_W          (4),
    .TIMEOUT_CYCLES (0)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en2),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done2),
    .pass      (pass2),
    .fail      (fail2),
    .timeout   (timeout2),
    .testnum   (testnum2),
    .cycle_cnt (cycle_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold reset over one negedge, release on the next negedge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a write at the next negedge; returns 1 time unit after its posedge.
  task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic d, input logic p,
                             input logic f, input logic t);
    check({tag, ".done"},    done,    d);
    check({tag, ".pass"},    pass,    p);
    check({tag, ".fail"},    fail,    f);
    check({tag, ".timeout"}, timeout, t);
  endtask

  // Reset release at negedge n0; idle posedge p1; writes land on p2, p3, p4.
  task automatic run_t1(input string tag);
    do_reset();
    write_reg(5'd3, 64'd5);
    write_reg(5'd27, 64'd1);
    check_flags({tag, ".pre"}, 1'b0, 1'b0, 1'b0, 1'b0);
    write_reg(5'd26, 64'd1);
    check_flags(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    check({tag, ".testnum"}, testnum, 64'd5);
    check({tag, ".cnt"}, cycle_cnt, 64'd4);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".cnt_hold"}, cycle_cnt, 64'd4);
    check({tag, ".pass_hold"}, pass, 1'b1);
  endtask

  initial begin
    // Reset state
    #2;
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.testnum", testnum, 64'd0);
    check("reset.cnt", cycle_cnt, 64'd0);

    // T1: pass
    run_t1("t1");

    // T2: fail, then later writes ignored
    do_reset();
    write_reg(5'd3, 64'd7);
    write_reg(5'd27, 64'd0);
    write_reg(5'd26, 64'd1);
    check_flags("t2", 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2.testnum", testnum, 64'd7);
    write_reg(5'd27, 64'd1);
    write_reg(5'd26, 64'd1);
    write_reg(5'd3, 64'd9);
    check_flags("t2.after", 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2.after.testnum", testnum, 64'd7);

    // T3: timeout after 20 RUN cycles; narrow DUT saturates without timeout
    do_reset();
    repeat (19) @(posedge clk);
    #1;
    check("t3.cnt19", cycle_cnt, 64'd19);
    check("t3.timeout19", timeout, 1'b0);
    @(posedge clk);
    #1;
    check_flags("t3", 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3.cnt20", cycle_cnt, 64'd20);
    repeat (5) @(posedge clk);
    #1;
    check("t3.cnt_hold", cycle_cnt, 64'd20);
    check("t3.timeout_hold", timeout, 1'b1);
    check("t3.sat_cnt", cycle_cnt2, 64'd15);
    check("t3.sat_timeout", timeout2, 1'b0);

    // T4: finish on the expiry edge (p20) wins
    do_reset();
    write_reg(5'd27, 64'd1);
    repeat (17) @(posedge clk);
    write_reg(5'd26, 64'd1);
    check_flags("t4", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t4.cnt", cycle_cnt, 64'd20);

    // T5: non-finish x26 values and x0 / other writes have no effect
    do_reset();
    write_reg(5'd26, 64'd2);
    write_reg(5'd26, 64'd0);
    write_reg(5'd26, 64'h0000_0001_0000_0001);
    write_reg(5'd0, 64'd1);
    write_reg(5'd4, 64'd3);
    check_flags("t5", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5.testnum", testnum, 64'd0);

    // T6: async reset mid-cycle after a pass, then a full pass again
    run_t1("t6.pre");
    #3;
    rst = 1'b1;
    #1;
    check_flags("t6.async", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6.testnum", testnum, 64'd0);
    check("t6.cnt", cycle_cnt, 64'd0);
    run_t1("t6.post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
